// File: rtl/track_select_ctrl_pkg.sv
// track_select_ctrl_pkg: shared defaults, FSM state codes and counter-width helper for track_select_ctrl
package track_select_ctrl_pkg;
  localparam int N_TRACKS_DEF = 8;
  localparam int IDX_W_DEF = 3;
  localparam int DEBOUNCE_CYC_DEF = 2_000_000;
  localparam int RPT_DELAY_CYC_DEF = 50_000_000;
  localparam int RPT_RATE_CYC_DEF = 15_000_000;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HELD = 2'd1;
  localparam logic [1:0] ST_REPEAT = 2'd2;
  function automatic int cnt_w(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    m = (m > c) ? m : c;
    return $clog2(m) + 1;
  endfunction
endpackage

// File: rtl/track_select_ctrl_btn_conditioner.sv
// btn_conditioner: 2-FF sync, debounce and hold auto-repeat of one raw button (clk, rst_n, btn -> step 1-cycle pulse per press/repeat)
module btn_conditioner
  import track_select_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEF,
  parameter int RPT_DELAY_CYC = RPT_DELAY_CYC_DEF,
  parameter int RPT_RATE_CYC = RPT_RATE_CYC_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic step
);
  localparam int W = cnt_w(DEBOUNCE_CYC, RPT_DELAY_CYC, RPT_RATE_CYC);
  logic s1, s, level;
  logic [W-1:0] dcnt, rcnt;
  logic [1:0] st;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s <= 1'b0;
      level <= 1'b0;
      dcnt <= '0;
    end else begin
      s1 <= btn;
      s <= s1;
      if (s == level) dcnt <= '0;
      else if (dcnt == W'(DEBOUNCE_CYC - 1)) begin
        level <= s;
        dcnt <= '0;
      end else dcnt <= dcnt + 1'b1;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st <= ST_IDLE;
      rcnt <= '0;
      step <= 1'b0;
    end else begin
      step <= 1'b0;
      if (st == ST_IDLE) begin
        if (level) begin
          st <= ST_HELD;
          step <= 1'b1;
          rcnt <= W'(RPT_DELAY_CYC);
        end
      end else if (!level) st <= ST_IDLE;
      else if (rcnt == W'(1)) begin
        st <= ST_REPEAT;
        step <= 1'b1;
        rcnt <= W'(RPT_RATE_CYC);
      end else rcnt <= rcnt - 1'b1;
    end
  end
endmodule

// File: rtl/track_select_ctrl.sv
// track_select_ctrl: conditioned next/pre buttons step a wrapping track index (clk, rst_n, i_next, i_pre -> o_next_pulse, o_pre_pulse, o_track_idx, o_changed)
module track_select_ctrl
  import track_select_ctrl_pkg::*;
#(
  parameter int N_TRACKS = N_TRACKS_DEF,
  parameter int IDX_W = IDX_W_DEF,
  parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEF,
  parameter int RPT_DELAY_CYC = RPT_DELAY_CYC_DEF,
  parameter int RPT_RATE_CYC = RPT_RATE_CYC_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_next,
  input  logic             i_pre,
  output logic             o_next_pulse,
  output logic             o_pre_pulse,
  output logic [IDX_W-1:0] o_track_idx,
  output logic             o_changed
);
  logic step_n, step_p, nx, pv;
  btn_conditioner #(.DEBOUNCE_CYC(DEBOUNCE_CYC), .RPT_DELAY_CYC(RPT_DELAY_CYC), .RPT_RATE_CYC(RPT_RATE_CYC))
    u_next (.clk(clk), .rst_n(rst_n), .btn(i_next), .step(step_n));
  btn_conditioner #(.DEBOUNCE_CYC(DEBOUNCE_CYC), .RPT_DELAY_CYC(RPT_DELAY_CYC), .RPT_RATE_CYC(RPT_RATE_CYC))
    u_pre (.clk(clk), .rst_n(rst_n), .btn(i_pre), .step(step_p));
  assign nx = step_n & ~step_p;
  assign pv = step_p & ~step_n;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_next_pulse <= 1'b0;
      o_pre_pulse <= 1'b0;
      o_changed <= 1'b0;
      o_track_idx <= '0;
    end else begin
      o_next_pulse <= nx;
      o_pre_pulse <= pv;
      o_changed <= nx | pv;
      if (nx) o_track_idx <= (o_track_idx == IDX_W'(N_TRACKS - 1)) ? '0 : o_track_idx + 1'b1;
      else if (pv) o_track_idx <= (o_track_idx == '0) ? IDX_W'(N_TRACKS - 1) : o_track_idx - 1'b1;
    end
  end
endmodule

// File: tb/tb_track_select_ctrl.sv
// tb_track_select_ctrl: directed and random stimulus against a cycle-level reference model of track_select_ctrl
module tb_track_select_ctrl;
  localparam int N = 5, W = 3, DEB = 4, DLY = 20, RATE = 8;
  logic clk = 1'b0, rst_n = 1'b0, i_next = 1'b0, i_pre = 1'b0;
  logic o_next_pulse, o_pre_pulse, o_changed;
  logic [W-1:0] o_track_idx;
  int checks = 0, errors = 0;
  int chg_cnt = 0, np_cnt = 0, pp_cnt = 0;
  bit p1[2], p2[2], lvl[2], stp[2];
  int run_len[2], acc[2];
  int cyc = 0, m_idx = 0;
  bit m_np = 0, m_pp = 0, m_ch = 0;
  track_select_ctrl #(.N_TRACKS(N), .IDX_W(W), .DEBOUNCE_CYC(DEB), .RPT_DELAY_CYC(DLY), .RPT_RATE_CYC(RATE)) dut (
    .clk(clk), .rst_n(rst_n), .i_next(i_next), .i_pre(i_pre),
    .o_next_pulse(o_next_pulse), .o_pre_pulse(o_pre_pulse), .o_track_idx(o_track_idx), .o_changed(o_changed)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic m_reset();
    for (int b = 0; b < 2; b++) begin
      p1[b] = 0; p2[b] = 0; lvl[b] = 0; stp[b] = 0; run_len[b] = 0; acc[b] = 0;
    end
    m_idx = 0; m_np = 0; m_pp = 0; m_ch = 0;
  endtask
  // A press accepted at edge a yields steps at a+1, then every D+kR edges later, while the level is still high
  function automatic bit step_due(input int b);
    int k;
    k = cyc - acc[b] - 1;
    return lvl[b] && (k == 0 || (k >= DLY && (k - DLY) % RATE == 0));
  endfunction
  task automatic m_edge();
    bit in_v[2];
    bit ns[2];
    in_v[0] = i_next;
    in_v[1] = i_pre;
    m_np = stp[0] && !stp[1];
    m_pp = stp[1] && !stp[0];
    m_ch = m_np || m_pp;
    if (m_np) m_idx = (m_idx + 1) % N;
    if (m_pp) m_idx = (m_idx + N - 1) % N;
    for (int b = 0; b < 2; b++) begin
      ns[b] = step_due(b);
      if (p2[b] != lvl[b]) begin
        run_len[b]++;
        if (run_len[b] == DEB) begin
          lvl[b] = p2[b];
          run_len[b] = 0;
          if (lvl[b]) acc[b] = cyc;
        end
      end else run_len[b] = 0;
      p2[b] = p1[b];
      p1[b] = in_v[b];
      stp[b] = ns[b];
    end
    cyc++;
  endtask
  task automatic tick();
    @(posedge clk);
    if (!rst_n) m_reset();
    else m_edge();
    #1;
    chk("next_pulse", o_next_pulse, m_np);
    chk("pre_pulse", o_pre_pulse, m_pp);
    chk("changed", o_changed, m_ch);
    chk("track_idx", o_track_idx, m_idx);
    if (o_changed === 1'b1) chg_cnt++;
    if (o_next_pulse === 1'b1) np_cnt++;
    if (o_pre_pulse === 1'b1) pp_cnt++;
  endtask
  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask
  task automatic press(input bit nx, input bit pr, input int h);
    i_next = nx;
    i_pre = pr;
    run(h);
    i_next = 1'b0;
    i_pre = 1'b0;
    run(15);
  endtask
  task automatic clr();
    chg_cnt = 0; np_cnt = 0; pp_cnt = 0;
  endtask
  initial begin
    m_reset();
    for (int i = 0; i < 6; i++) begin
      i_next = 1'($urandom_range(0, 1));
      i_pre = 1'($urandom_range(0, 1));
      tick();
    end
    i_next = 1'b0;
    i_pre = 1'b0;
    tick();
    chk("rst_idx", o_track_idx, 0);
    rst_n = 1'b1;
    run(10);
    chk("post_rst_chg", chg_cnt, 0);
    clr();
    press(1, 0, 3);
    chk("glitch_chg", chg_cnt, 0);
    chk("glitch_idx", o_track_idx, 0);
    press(1, 0, 15);
    chk("press_chg", chg_cnt, 1);
    chk("press_np", np_cnt, 1);
    chk("press_idx", o_track_idx, 1);
    press(1, 0, 10);
    press(1, 0, 10);
    press(1, 0, 10);
    chk("idx4", o_track_idx, 4);
    press(1, 0, 10);
    chk("wrap_up_idx", o_track_idx, 0);
    clr();
    press(0, 1, 10);
    chk("wrap_dn_idx", o_track_idx, 4);
    chk("wrap_dn_pp", pp_cnt, 1);
    press(1, 0, 10);
    clr();
    press(1, 0, 57);
    chk("repeat_chg", chg_cnt, 6);
    chk("repeat_idx", o_track_idx, 1);
    clr();
    press(1, 1, 10);
    chk("simul_chg", chg_cnt, 0);
    chk("simul_idx", o_track_idx, 1);
    clr();
    i_next = 1'b1;
    run(2);
    i_pre = 1'b1;
    run(10);
    i_next = 1'b0;
    i_pre = 1'b0;
    run(15);
    chk("stagger_chg", chg_cnt, 2);
    chk("stagger_np", np_cnt, 1);
    chk("stagger_pp", pp_cnt, 1);
    chk("stagger_idx", o_track_idx, 1);
    i_next = 1'b1;
    run(40);
    #2 rst_n = 1'b0;
    m_reset();
    #1;
    chk("async_rst_idx", o_track_idx, 0);
    chk("async_rst_chg", o_changed, 0);
    chk("async_rst_np", o_next_pulse, 0);
    run(3);
    rst_n = 1'b1;
    clr();
    run(15);
    i_next = 1'b0;
    run(15);
    chk("held_rst_chg", chg_cnt, 1);
    chk("held_rst_idx", o_track_idx, 1);
    for (int s = 0; s < 60; s++) begin
      i_next = 1'($urandom_range(0, 1));
      i_pre = 1'($urandom_range(0, 1));
      run(int'($urandom_range(1, 30)));
    end
    i_next = 1'b0;
    i_pre = 1'b0;
    run(20);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
